// File: rtl/skid_buffer.sv
// skid_buffer: two-entry elastic pipeline stage with a valid/ready handshake.
// in_ready, out_valid and out_data all come straight from flops, so no
// combinational path runs from out_ready back to in_ready.
// Optional build macro SKID_BUF_STALL_CNT_EN adds a saturating 16-bit
// consumer-stall counter on port stall_cnt.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   EMPTY | no word held, out_valid=0
//   BUSY  | main register holds one word, in_ready=1
//   FULL  | main and skid registers both hold a word, in_ready=0
module skid_buffer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SKID_BUF_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer;

  // in_data is only looked at on an accepted transfer, so X on an idle bus
  // never reaches the registers.
  assign in_xfer   = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = data_q;

  // State, ready and data registers; reset discards any in-flight words.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      data_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      data_q     <= data_d;
      skid_q     <= skid_d;
    end
  end

  // Next-state and next-data logic; in_ready defaults high and drops only
  // when the stage is (or is about to be) FULL.
  always_comb begin
    state_d    = state_q;
    in_ready_d = 1'b1;
    data_d     = data_q;
    skid_d     = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          data_d  = in_data;
        end
      end
      BUSY: begin
        if (in_xfer && out_ready) begin
          data_d = in_data;
        end else if (in_xfer) begin
          state_d    = FULL;
          skid_d     = in_data;
          in_ready_d = 1'b0;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready_q is low here, so in_valid cannot be accepted.
        if (out_ready) begin
          state_d = BUSY;
          data_d  = skid_q;
        end else begin
          in_ready_d = 1'b0;
        end
      end
      default: begin
        state_d    = EMPTY;
        in_ready_d = 1'b0;
      end
    endcase
  end

`ifdef SKID_BUF_STALL_CNT_EN
  logic [15:0] stall_q;

  assign stall_cnt = stall_q;

  // Count cycles where a word is offered but not taken; stick at all-ones.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      stall_q <= 16'h0000;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  logic just_rel_q;

  // Marks the first cycle after reset release, when in_ready is still low.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      just_rel_q <= 1'b1;
    end else begin
      just_rel_q <= 1'b0;
    end
  end

  a_state_legal : assert property (@(posedge clk) disable iff (!r_n)
    state_q inside {EMPTY, BUSY, FULL});

  a_ready_low_only_full : assert property (@(posedge clk) disable iff (!r_n)
    !in_ready_q |-> ((state_q == FULL) || just_rel_q));
`endif

endmodule
